// File: rtl/vga_timing_if.sv
// Pixel-enable/restart inputs and the raster position/sync outputs of the VGA timing generator.
// The master modport is the generator; the slave modport is the consumer or stimulus side.
interface vga_timing_if #(
  parameter int CW = 12
);
  logic          pix_en;
  logic          sync_clr;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_end;
  logic          frame_end;

  modport master (
    input  pix_en, sync_clr,
    output h_count, v_count, hsync, vsync, active, line_end, frame_end
  );

  modport slave (
    output pix_en, sync_clr,
    input  h_count, v_count, hsync, vsync, active, line_end, frame_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered sync, active and end strobes
// that are derived from the next counter values so they line up with the counters they accompany.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      (2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_param_check
    $error("vga_timing_gen: zero timing parameter or CW too narrow for the totals");
  end

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] h_reg, h_next;
  logic [CW-1:0] v_reg, v_next;
  logic          hsync_reg, vsync_reg, active_reg, line_end_reg, frame_end_reg;
  logic          hs_win_next, vs_win_next;

  // ">=" rather than "==" so a corrupted counter falls back to 0 on the next enabled edge.
  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (bus.sync_clr) begin
      h_next = '0;
      v_next = '0;
    end else if (bus.pix_en) begin
      if (h_reg >= H_LAST) begin
        h_next = '0;
        v_next = (v_reg >= V_LAST) ? '0 : v_reg + ONE;
      end else begin
        h_next = h_reg + ONE;
        if (v_reg > V_LAST) begin
          v_next = '0;
        end
      end
    end
  end

  assign hs_win_next = (h_next >= HS_START) && (h_next <= HS_STOP);
  assign vs_win_next = (v_next >= VS_START) && (v_next <= VS_STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg         <= '0;
      v_reg         <= '0;
      hsync_reg     <= ~HS_POL;
      vsync_reg     <= ~VS_POL;
      active_reg    <= 1'b1;
      line_end_reg  <= 1'b0;
      frame_end_reg <= 1'b0;
    end else begin
      h_reg         <= h_next;
      v_reg         <= v_next;
      hsync_reg     <= hs_win_next ? HS_POL : ~HS_POL;
      vsync_reg     <= vs_win_next ? VS_POL : ~VS_POL;
      active_reg    <= (h_next < H_VIS) && (v_next < V_VIS);
      line_end_reg  <= (h_next == H_LAST);
      frame_end_reg <= (h_next == H_LAST) && (v_next == V_LAST);
    end
  end

  assign bus.h_count   = h_reg;
  assign bus.v_count   = v_reg;
  assign bus.hsync     = hsync_reg;
  assign bus.vsync     = vsync_reg;
  assign bus.active    = active_reg;
  assign bus.line_end  = line_end_reg;
  assign bus.frame_end = frame_end_reg;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level checks and a tiny-timing,
// active-high-sync instance for whole-frame, enable, reset and restart checks.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d;
  logic rst_s;

  vga_timing_if #(.CW(12)) if_d ();
  vga_timing_if #(.CW(5))  if_s ();

  vga_timing_gen u_def (
    .clk (clk),
    .rst (rst_d),
    .bus (if_d.master)
  );

  // Small raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, frame = 120 enabled edges.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
  ) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (if_s.master)
  );

  int errors = 0;
  int checks = 0;
  int hm = 0;
  int vm = 0;

  logic [14:0] got_small;
  logic [28:0] got_def;
  assign got_small = {if_s.h_count, if_s.v_count, if_s.hsync, if_s.vsync,
                      if_s.active, if_s.line_end, if_s.frame_end};
  assign got_def   = {if_d.h_count, if_d.v_count, if_d.hsync, if_d.vsync,
                      if_d.active, if_d.line_end, if_d.frame_end};

  // {h, v, hsync, vsync, active, line_end, frame_end} expected for the small raster.
  function automatic logic [14:0] exp_small(input int h, input int v);
    logic hs, vs, act, le, fe;
    hs  = (h >= 10) && (h <= 12);
    vs  = (v >= 5) && (v <= 6);
    act = (h < 8) && (v < 4);
    le  = (h == 14);
    fe  = (h == 14) && (v == 7);
    return {5'(h), 5'(v), hs, vs, act, le, fe};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    if (hm == 14) begin
      hm = 0;
      vm = (vm == 7) ? 0 : vm + 1;
    end else begin
      hm = hm + 1;
    end
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    rst_s = 1'b1;
    if_d.pix_en = 1'b1;
    if_d.sync_clr = 1'b0;
    if_s.pix_en = 1'b1;
    if_s.sync_clr = 1'b0;
    step();
    step();
    checks++;
    if (got_def !== {12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_default got=%h exp=%h", got_def,
               {12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    checks++;
    if (got_small !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_small got=%h exp=%h", got_small,
               {5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    $display("test_reset done");
  endtask

  task automatic test_line_default();
    logic [28:0] exp;
    int eh, ev;
    rst_d = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      step();
      eh = i % 800;
      ev = i / 800;
      exp = {12'(eh), 12'(ev), !((eh >= 656) && (eh <= 751)), 1'b1,
             (eh < 640) && (ev < 480), eh == 799, 1'b0};
      checks++;
      if (got_def !== exp) begin
        errors++;
        $display("FAIL line_default edge=%0d got=%h exp=%h", i, got_def, exp);
      end
    end
    if_d.pix_en = 1'b0;
    $display("test_line_default done: 800 edges");
  endtask

  task automatic test_frame_small();
    int fe_count = 0;
    rst_s = 1'b0;
    hm = 0;
    vm = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      adv();
      if (got_small[0]) fe_count++;
      checks++;
      if (got_small !== exp_small(hm, vm)) begin
        errors++;
        $display("FAIL frame_small edge=%0d got=%h exp=%h", i, got_small, exp_small(hm, vm));
      end
    end
    checks++;
    if (fe_count !== 2) begin
      errors++;
      $display("FAIL frame_end_count got=%0d exp=2", fe_count);
    end
    $display("test_frame_small done: frame_end pulses=%0d", fe_count);
  endtask

  task automatic test_enable_toggle();
    int first_rise = -1;
    int second_rise = -1;
    logic prev_fe = 1'b0;
    for (int i = 0; i < 480; i++) begin
      if_s.pix_en = (i % 2 == 0);
      step();
      if (i % 2 == 0) adv();
      checks++;
      if (got_small !== exp_small(hm, vm)) begin
        errors++;
        $display("FAIL enable_toggle cyc=%0d got=%h exp=%h", i, got_small, exp_small(hm, vm));
      end
      if (got_small[0] && !prev_fe) begin
        if (first_rise < 0) first_rise = i;
        else if (second_rise < 0) second_rise = i;
      end
      prev_fe = got_small[0];
    end
    if_s.pix_en = 1'b0;
    checks++;
    if (second_rise - first_rise !== 240) begin
      errors++;
      $display("FAIL enable_toggle_period got=%0d exp=240", second_rise - first_rise);
    end
    $display("test_enable_toggle done: frame_end rises at %0d and %0d", first_rise, second_rise);
  endtask

  task automatic test_reset_midframe();
    if_s.pix_en = 1'b1;
    for (int i = 0; i < 51; i++) begin
      step();
      adv();
    end
    checks++;
    if (got_small !== exp_small(6, 3)) begin
      errors++;
      $display("FAIL pre_reset_pos got=%h exp=%h", got_small, exp_small(6, 3));
    end
    #2;
    rst_s = 1'b1;
    #1;
    checks++;
    if (got_small !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", got_small,
               {5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    #1;
    rst_s = 1'b0;
    step();
    hm = 1;
    vm = 0;
    checks++;
    if (got_small !== exp_small(1, 0)) begin
      errors++;
      $display("FAIL first_edge_after_reset got=%h exp=%h", got_small, exp_small(1, 0));
    end
    $display("test_reset_midframe done");
  endtask

  task automatic test_sync_clr();
    int guard = 0;
    if_s.pix_en = 1'b1;
    while (!(hm == 10 && vm == 5) && guard < 200) begin
      step();
      adv();
      guard++;
    end
    checks++;
    if (got_small !== exp_small(10, 5)) begin
      errors++;
      $display("FAIL reach_10_5 got=%h exp=%h", got_small, exp_small(10, 5));
    end
    if_s.pix_en = 1'b0;
    if_s.sync_clr = 1'b1;
    step();
    checks++;
    if (got_small !== exp_small(0, 0)) begin
      errors++;
      $display("FAIL sync_clr_no_en got=%h exp=%h", got_small, exp_small(0, 0));
    end
    if_s.sync_clr = 1'b0;
    step();
    checks++;
    if (got_small !== exp_small(0, 0)) begin
      errors++;
      $display("FAIL hold_after_clr got=%h exp=%h", got_small, exp_small(0, 0));
    end
    hm = 0;
    vm = 0;
    if_s.pix_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      adv();
    end
    checks++;
    if (got_small !== exp_small(5, 1)) begin
      errors++;
      $display("FAIL advance_5_1 got=%h exp=%h", got_small, exp_small(5, 1));
    end
    if_s.sync_clr = 1'b1;
    step();
    checks++;
    if (got_small !== exp_small(0, 0)) begin
      errors++;
      $display("FAIL sync_clr_priority got=%h exp=%h", got_small, exp_small(0, 0));
    end
    if_s.sync_clr = 1'b0;
    if_s.pix_en = 1'b0;
    $display("test_sync_clr done");
  endtask

  initial begin
    test_reset();
    test_line_default();
    test_frame_small();
    test_enable_toggle();
    test_reset_midframe();
    test_sync_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
